// File: rtl/adpll_mon_pkg.sv
// Shared types and default sizes for the ADPLL lock monitor.
`timescale 1ns/1ps
package adpll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } monState_e;

  localparam int SYNC_STAGES  = 2;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_WIN_LOG2 = 8;
  localparam int DEF_LOCK_N   = 4;

endpackage

// File: rtl/adpll_lock_monitor_if.sv
// Control/status bundle between the lock monitor and its environment.
// ADPLL_MON_STICKY_UNLOCK_EN adds the sticky unlock flag and its clear.
`timescale 1ns/1ps
interface adpll_lock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             dco_in;
  logic [CNT_W-1:0] target;
  logic [3:0]       tol;
  logic [CNT_W-1:0] count_out;
  logic [CNT_W:0]   err_out;
  logic             win_valid;
  logic             locked;
  logic [1:0]       state_out;
`ifdef ADPLL_MON_STICKY_UNLOCK_EN
  logic             unlock_clr;
  logic             unlock_seen;

  modport master (
    output ena, dco_in, target, tol, unlock_clr,
    input  count_out, err_out, win_valid, locked, state_out, unlock_seen
  );

  modport slave (
    input  ena, dco_in, target, tol, unlock_clr,
    output count_out, err_out, win_valid, locked, state_out, unlock_seen
  );
`else
  modport master (
    output ena, dco_in, target, tol,
    input  count_out, err_out, win_valid, locked, state_out
  );

  modport slave (
    input  ena, dco_in, target, tol,
    output count_out, err_out, win_valid, locked, state_out
  );
`endif

endinterface

// File: rtl/adpll_edge_sync.sv
// Brings the asynchronous DCO into the clk domain and flags its rising edges.
`timescale 1ns/1ps
module adpll_edge_sync
  import adpll_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dcoAsync_i,
  output logic risePulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dcoAsync_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign risePulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adpll_lock_monitor.sv
// Counts DCO edges per fixed clk window, compares against target and tracks lock.
// ADPLL_MON_STICKY_UNLOCK_EN adds a sticky record of LOCKED->ACQUIRE drops.
`timescale 1ns/1ps
module adpll_lock_monitor
  import adpll_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int LOCK_N   = DEF_LOCK_N
)(
  input  logic                 clk,
  input  logic                 rst_n,
  adpll_lock_monitor_if.slave  mon
);

  localparam logic [WIN_LOG2-1:0] TIMER_LAST = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [3:0]          LOCK_LVL   = 4'(LOCK_N);

  monState_e           state_q, state_d;
  logic [WIN_LOG2-1:0] winTimer_q, winTimer_d;
  logic [CNT_W-1:0]    edgeCnt_q, edgeCnt_d;
  logic [3:0]          goodCnt_q, goodCnt_d;
  logic [CNT_W-1:0]    countOut_q, countOut_d;
  logic [CNT_W:0]      errOut_q, errOut_d;
  logic                winValid_q, winValid_d;
  logic                locked_q;

  logic                risePulse;
  logic                running;
  logic                winEnd;
  logic [CNT_W-1:0]    finalCnt;
  logic [CNT_W:0]      winErr;
  logic [CNT_W:0]      absErr;
  logic                winGood;
  logic [3:0]          goodNext;

  adpll_edge_sync u_edgeSync (
    .clk         (clk),
    .rst_n       (rst_n),
    .dcoAsync_i  (mon.dco_in),
    .risePulse_o (risePulse)
  );

  // Dropping ena aborts the window in the same cycle it is seen low.
  assign running  = (state_q != IDLE) && mon.ena;
  assign winEnd   = running && (winTimer_q == TIMER_LAST);
  assign finalCnt = (risePulse && (edgeCnt_q != CNT_MAX)) ? edgeCnt_q + CNT_W'(1) : edgeCnt_q;
  assign winErr   = {1'b0, finalCnt} - {1'b0, mon.target};
  assign absErr   = winErr[CNT_W] ? -winErr : winErr;
  assign winGood  = absErr <= {{(CNT_W-3){1'b0}}, mon.tol};
  assign goodNext = !winGood ? 4'd0 :
                    (goodCnt_q >= LOCK_LVL) ? LOCK_LVL : goodCnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mon.ena) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (!mon.ena) state_d = IDLE;
        else if (winEnd && (goodNext == LOCK_LVL)) state_d = LOCKED;
      end
      LOCKED: begin
        if (!mon.ena) state_d = IDLE;
        else if (winEnd && !winGood) state_d = ACQUIRE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    winTimer_d = running ? winTimer_q + WIN_LOG2'(1) : '0;
    edgeCnt_d  = (!running || winEnd) ? '0 : finalCnt;
    goodCnt_d  = !running ? 4'd0 : (winEnd ? goodNext : goodCnt_q);
    countOut_d = winEnd ? finalCnt : countOut_q;
    errOut_d   = winEnd ? winErr : errOut_q;
    winValid_d = winEnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winTimer_q <= '0;
      edgeCnt_q  <= '0;
      goodCnt_q  <= 4'd0;
      countOut_q <= '0;
      errOut_q   <= '0;
      winValid_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      winTimer_q <= winTimer_d;
      edgeCnt_q  <= edgeCnt_d;
      goodCnt_q  <= goodCnt_d;
      countOut_q <= countOut_d;
      errOut_q   <= errOut_d;
      winValid_q <= winValid_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

`ifdef ADPLL_MON_STICKY_UNLOCK_EN
  logic unlockSeen_q, unlockSeen_d;

  // A loss of lock in the same cycle as a clear must still be recorded.
  always_comb begin
    unlockSeen_d = unlockSeen_q;
    if (mon.unlock_clr) unlockSeen_d = 1'b0;
    if ((state_q == LOCKED) && (state_d == ACQUIRE)) unlockSeen_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unlockSeen_q <= 1'b0;
    else        unlockSeen_q <= unlockSeen_d;
  end

  assign mon.unlock_seen = unlockSeen_q;
`endif

  assign mon.count_out = countOut_q;
  assign mon.err_out   = errOut_q;
  assign mon.win_valid = winValid_q;
  assign mon.locked    = locked_q;
  assign mon.state_out = state_q;

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Scoreboarded bench for adpll_lock_monitor; a second instance with 1024-cycle
// windows covers edge-counter saturation. Honours ADPLL_MON_STICKY_UNLOCK_EN.
`timescale 1ns/1ps
module tb_adpll_lock_monitor;

  typedef struct {
    bit         chkCnt;
    logic [7:0] cntLo;
    logic [7:0] cntHi;
    logic [7:0] tgt;
    logic       expLocked;
  } sbEntry_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   dcoPeriod;
  logic genDco;
  logic manDco;
  logic bDco;

  sbEntry_t   sbQ[$];
  sbEntry_t   sbHead;
  logic [8:0] errLo, errHi;

  adpll_lock_monitor_if #(.CNT_W(8)) aIf ();
  adpll_lock_monitor_if #(.CNT_W(8)) bIf ();

  adpll_lock_monitor #(.CNT_W(8), .WIN_LOG2(8), .LOCK_N(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (aIf.slave)
  );

  adpll_lock_monitor #(.CNT_W(8), .WIN_LOG2(10), .LOCK_N(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DCO model: period in clk cycles, edges 3 ns after clk rises; period 0 hands over to manDco.
  initial begin
    genDco = 1'b0;
    forever begin
      if (dcoPeriod == 0) begin
        genDco = 1'b0;
        @(posedge clk);
        #3;
      end else begin
        genDco = 1'b1;
        #(dcoPeriod * 5);
        genDco = 1'b0;
        #(dcoPeriod * 5);
      end
    end
  end

  initial begin
    bDco = 1'b0;
    #8;
    forever begin
      bDco = 1'b1;
      #10;
      bDco = 1'b0;
      #10;
    end
  end

  assign aIf.dco_in = (dcoPeriod != 0) ? genDco : manDco;
  assign bIf.dco_in = bDco;

  // Scoreboard: every win_valid on dutA consumes one queued expectation.
  always @(negedge clk) begin
    if (rst_n && aIf.win_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected_window count_out=%0d err_out=%h required=no window", aIf.count_out, aIf.err_out);
      end else begin
        sbHead = sbQ.pop_front();
        if (sbHead.chkCnt) begin
          errLo = {1'b0, sbHead.cntLo} - {1'b0, sbHead.tgt};
          errHi = {1'b0, sbHead.cntHi} - {1'b0, sbHead.tgt};
          checks++;
          if (!((aIf.count_out === sbHead.cntLo && aIf.err_out === errLo) ||
                (aIf.count_out === sbHead.cntHi && aIf.err_out === errHi))) begin
            errors++;
            $display("[TB] FAIL sb_window got count=%0d err=%h required count=%0d/%0d err=%h/%h",
                     aIf.count_out, aIf.err_out, sbHead.cntLo, sbHead.cntHi, errLo, errHi);
          end
        end
        checks++;
        if (aIf.locked !== sbHead.expLocked) begin
          errors++;
          $display("[TB] FAIL sb_locked got=%b required=%b", aIf.locked, sbHead.expLocked);
        end
      end
    end
  end

  task automatic waitWindow(input bit useB, input int budget, input string tag,
                            output bit got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((useB ? bIf.win_valid : aIf.win_valid) === 1'b1) begin
        got    = 1'b1;
        cycles = i;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout got=no win_valid in %0d cycles required=win_valid", tag, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (aIf.count_out !== 8'd0 || aIf.err_out !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got count=%h err=%h required=0/0", aIf.count_out, aIf.err_out);
    end
    checks++;
    if (aIf.win_valid !== 1'b0 || aIf.locked !== 1'b0 || aIf.state_out !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got valid=%b locked=%b state=%0d required=0/0/0",
               aIf.win_valid, aIf.locked, aIf.state_out);
    end
    checks++;
    if (bIf.count_out !== 8'd0 || bIf.state_out !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_dutB got count=%h state=%0d required=0/0", bIf.count_out, bIf.state_out);
    end
`ifdef ADPLL_MON_STICKY_UNLOCK_EN
    checks++;
    if (aIf.unlock_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_unlock_seen got=%b required=0", aIf.unlock_seen);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_lock_acquire();
    bit got;
    int cyc;
    aIf.target = 8'd32;
    aIf.tol    = 4'd1;
    dcoPeriod  = 8;
    repeat (20) @(posedge clk);
    #1 aIf.ena = 1'b1;
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b0});
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b0});
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b0});
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b1});
    for (int w = 0; w < 4; w++) begin
      waitWindow(1'b0, 300, "acquire", got, cyc);
      if (!got) return;
      if (w > 0) begin
        checks++;
        if (cyc !== 256) begin
          errors++;
          $display("[TB] FAIL acquire_interval got=%0d required=256", cyc);
        end
      end
    end
    checks++;
    if (aIf.state_out !== 2'd2) begin
      errors++;
      $display("[TB] FAIL acquire_state got=%0d required=2", aIf.state_out);
    end
  endtask

  task automatic test_loss_of_lock();
    bit got;
    int cyc;
    dcoPeriod = 10;
    sbQ.push_back('{1'b0, 8'd0, 8'd0, 8'd32, 1'b0});
    sbQ.push_back('{1'b1, 8'd25, 8'd26, 8'd32, 1'b0});
    waitWindow(1'b0, 300, "loss", got, cyc);
    if (!got) return;
    checks++;
    if (aIf.state_out !== 2'd1) begin
      errors++;
      $display("[TB] FAIL loss_state got=%0d required=1", aIf.state_out);
    end
`ifdef ADPLL_MON_STICKY_UNLOCK_EN
    checks++;
    if (aIf.unlock_seen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loss_unlock_set got=%b required=1", aIf.unlock_seen);
    end
`endif
    waitWindow(1'b0, 300, "loss", got, cyc);
    if (!got) return;
`ifdef ADPLL_MON_STICKY_UNLOCK_EN
    checks++;
    if (aIf.unlock_seen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loss_unlock_hold got=%b required=1", aIf.unlock_seen);
    end
    @(posedge clk);
    #1 aIf.unlock_clr = 1'b1;
    @(posedge clk);
    #1 aIf.unlock_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (aIf.unlock_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loss_unlock_clr got=%b required=0", aIf.unlock_seen);
    end
`endif
    aIf.ena = 1'b0;
  endtask

  task automatic test_tolerance();
    bit got;
    int cyc;
    dcoPeriod  = 8;
    aIf.target = 8'd30;
    aIf.tol    = 4'd2;
    repeat (20) @(posedge clk);
    #1 aIf.ena = 1'b1;
    for (int i = 0; i < 7; i++) sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd30, 1'b0});
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd30, 1'b1});
    for (int w = 0; w < 3; w++) begin
      waitWindow(1'b0, 300, "tol_good", got, cyc);
      if (!got) return;
    end
    repeat (128) @(posedge clk);
    #1 aIf.tol = 4'd1;
    waitWindow(1'b0, 300, "tol_bad", got, cyc);
    if (!got) return;
    aIf.tol = 4'd2;
    for (int w = 0; w < 4; w++) begin
      waitWindow(1'b0, 300, "tol_relock", got, cyc);
      if (!got) return;
    end
    aIf.ena = 1'b0;
  endtask

  task automatic test_edge_at_end();
    bit got;
    int cyc;
    dcoPeriod  = 0;
    manDco     = 1'b0;
    aIf.target = 8'd1;
    aIf.tol    = 4'd0;
    repeat (20) @(posedge clk);
    #1 aIf.ena = 1'b1;
    sbQ.push_back('{1'b1, 8'd0, 8'd0, 8'd1, 1'b0});
    sbQ.push_back('{1'b1, 8'd1, 8'd1, 8'd1, 1'b0});
    sbQ.push_back('{1'b1, 8'd0, 8'd0, 8'd1, 1'b0});
    waitWindow(1'b0, 300, "edge_w1", got, cyc);
    if (!got) return;
    repeat (253) @(posedge clk);
    #1 manDco = 1'b1;
    waitWindow(1'b0, 10, "edge_w2", got, cyc);
    if (!got) return;
    manDco = 1'b0;
    waitWindow(1'b0, 300, "edge_w3", got, cyc);
    if (!got) return;
    checks++;
    if (cyc !== 256) begin
      errors++;
      $display("[TB] FAIL edge_next_window got=%0d required=256", cyc);
    end
    aIf.ena = 1'b0;
  endtask

  task automatic test_abort();
    bit got;
    bit sawValid;
    int cyc;
    dcoPeriod  = 8;
    aIf.target = 8'd32;
    aIf.tol    = 4'd1;
    repeat (20) @(posedge clk);
    #1 aIf.ena = 1'b1;
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b0});
    waitWindow(1'b0, 300, "abort_first", got, cyc);
    if (!got) return;
    repeat (100) @(posedge clk);
    #1 aIf.ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (aIf.state_out !== 2'd0 || aIf.win_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state got state=%0d valid=%b required=0/0", aIf.state_out, aIf.win_valid);
    end
    checks++;
    if (aIf.count_out !== 8'd32 || aIf.err_out !== 9'd0) begin
      errors++;
      $display("[TB] FAIL abort_hold got count=%0d err=%h required=32/000", aIf.count_out, aIf.err_out);
    end
    sawValid = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (aIf.win_valid === 1'b1) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("[TB] FAIL abort_no_valid got=win_valid required=none");
    end
  endtask

  task automatic test_reset_mid_window();
    bit got;
    int cyc;
    @(posedge clk);
    #1 aIf.ena = 1'b1;
    for (int i = 0; i < 3; i++) sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b0});
    sbQ.push_back('{1'b1, 8'd32, 8'd32, 8'd32, 1'b1});
    for (int w = 0; w < 4; w++) begin
      waitWindow(1'b0, 300, "rstmid", got, cyc);
      if (!got) return;
    end
    repeat (100) @(posedge clk);
    #3;
    checks++;
    if (aIf.locked !== 1'b1 || aIf.count_out !== 8'd32) begin
      errors++;
      $display("[TB] FAIL rstmid_pre got locked=%b count=%0d required=1/32", aIf.locked, aIf.count_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (aIf.count_out !== 8'd0 || aIf.err_out !== 9'd0 || aIf.locked !== 1'b0 ||
        aIf.state_out !== 2'd0 || aIf.win_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_async got count=%h err=%h locked=%b state=%0d valid=%b required=all 0",
               aIf.count_out, aIf.err_out, aIf.locked, aIf.state_out, aIf.win_valid);
    end
    repeat (2) @(negedge clk);
    aIf.ena = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    bit got;
    int cyc;
    bIf.target = 8'd200;
    bIf.tol    = 4'd0;
    @(posedge clk);
    #1 bIf.ena = 1'b1;
    waitWindow(1'b1, 1100, "sat_first", got, cyc);
    if (!got) return;
    checks++;
    if (bIf.count_out !== 8'd255 || bIf.err_out !== 9'h037) begin
      errors++;
      $display("[TB] FAIL sat_value got count=%0d err=%h required=255/037", bIf.count_out, bIf.err_out);
    end
    checks++;
    if (bIf.locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_locked got=%b required=0", bIf.locked);
    end
    waitWindow(1'b1, 1100, "sat_second", got, cyc);
    if (!got) return;
    checks++;
    if (cyc !== 1024 || bIf.count_out !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_interval got cycles=%0d count=%0d required=1024/255", cyc, bIf.count_out);
    end
    bIf.ena = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    dcoPeriod  = 8;
    manDco     = 1'b0;
    aIf.ena    = 1'b0;
    aIf.target = 8'd0;
    aIf.tol    = 4'd0;
    bIf.ena    = 1'b0;
    bIf.target = 8'd0;
    bIf.tol    = 4'd0;
`ifdef ADPLL_MON_STICKY_UNLOCK_EN
    aIf.unlock_clr = 1'b0;
    bIf.unlock_clr = 1'b0;
`endif
    test_reset();
    test_lock_acquire();
    test_loss_of_lock();
    test_tolerance();
    test_edge_at_end();
    test_abort();
    test_reset_mid_window();
    test_saturation();
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain got=%0d pending required=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
